// File: rtl/down_cnt_timer.sv
// Cascadable 8-bit down-counting timer.
// One-shot or auto-reload, with a reload register and terminal-count chaining.
module down_cnt_timer (
  input  logic       clk,
  input  logic       R_n,
  input  logic       ce,
  input  logic       ld,
  input  logic [7:0] D,
  input  logic       mode,
  input  logic       start,
  input  logic       stop,
  output logic [7:0] Q,
  output logic       TC,
  output logic       CEO,
  output logic       busy,
  output logic       done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] q_q, q_d;
  logic [7:0] rld_q, rld_d;
  logic       done_q, done_d;
  logic [7:0] load_val;
  logic       expire;

  // Reload source: a same-edge ld bypasses the reload register.
  always_comb begin
    load_val = ld ? D : rld_q;
    expire   = (state_q == RUN) && ce && (q_q == 8'd0);
  end

  // State register.
  always_ff @(posedge clk or negedge R_n) begin
    if (!R_n) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state: stop beats start beats counting.
  always_comb begin
    state_d = state_q;
    priority case (1'b1)
      stop:    state_d = IDLE;
      start:   state_d = RUN;
      default: if (expire && !mode) state_d = IDLE;
    endcase
  end

  // Count, reload register and expiry pulse.
  always_comb begin
    q_d    = q_q;
    done_d = 1'b0;
    rld_d  = ld ? D : rld_q;
    priority case (1'b1)
      stop:  q_d = q_q;
      start: q_d = load_val;
      default: begin
        if (state_q == RUN && ce) begin
          if (q_q != 8'd0) begin
            q_d = q_q - 8'd1;
          end else begin
            done_d = 1'b1;
            if (mode) q_d = load_val;
          end
        end
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge R_n) begin
    if (!R_n) begin
      q_q    <= 8'd0;
      rld_q  <= 8'd0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      rld_q  <= rld_d;
      done_q <= done_d;
    end
  end

  // Outputs; TC and CEO stay combinational for zero-latency cascading.
  always_comb begin
    Q    = q_q;
    busy = (state_q == RUN);
    done = done_q;
    TC   = (q_q == 8'd0);
    CEO  = ce && TC && (state_q == RUN);
  end

endmodule
